t_toggle_counter: RTL and testbench



---
 rtl/t_toggle_counter_pkg.sv | 10 +
 rtl/t_toggle_counter_cell.sv | 24 ++
 rtl/t_toggle_counter.sv | 87 ++++++++
 tb/tb_t_toggle_counter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/t_toggle_counter_pkg.sv
// Shared constants for the T-cell up/down counter: direction encoding and default geometry.
package t_toggle_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 10;

endpackage

// File: rtl/t_toggle_counter_cell.sv
// One counter bit: a T flip-flop with synchronous reset and parallel load.
// Per edge: reset clears, else ld takes d, else t toggles, else hold.
module t_cell
    import t_toggle_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_toggle_counter.sv
// Up/down counter built from WIDTH t_cell bits with load, terminal count and sticky wrap flag.
// Define T_TOGGLE_COUNTER_MOD_EN to make it wrap at MODULUS instead of 2^WIDTH.
module t_toggle_counter
    import t_toggle_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] term_up;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] t_mask;
    logic [WIDTH-1:0] cnt_t;
    logic             run;
    logic             count_up;

    assign count_up = (up == DIR_UP);

`ifdef T_TOGGLE_COUNTER_MOD_EN
    localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);

    logic wrap_now;

    assign term_up = MOD_MAX;
    assign load_d  = (load_val > MOD_MAX) ? MOD_MAX : load_val;
    // Leaving the range in either direction forces the wrapped value directly.
    assign wrap_now = count_up ? (q >= MOD_MAX) : (q == '0);
`else
    assign term_up = '1;
    assign load_d  = load_val;
    // MODULUS only matters in the modulo build.
    if (MODULUS < 2) begin : g_modulus_ignored
    end
`endif

    assign terminal = count_up ? term_up : '0;
    assign tc       = en & ~load & (q == terminal);

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        t_mask = '0;
        run    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_mask[i] = run;
            run       = run & (count_up ? q[i] : ~q[i]);
        end
`ifdef T_TOGGLE_COUNTER_MOD_EN
        if (wrap_now) begin
            t_mask = q ^ (count_up ? '0 : MOD_MAX);
        end
`endif
        cnt_t = en ? t_mask : '0;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .ld    (load),
            .d     (load_d[i]),
            .t     (cnt_t[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= 1'b0;
        end else if (tc) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_t_toggle_counter.sv
// Self-checking bench for t_toggle_counter (WIDTH=4, MODULUS=10), directed tables plus random steps.
module tb_t_toggle_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;
`ifdef T_TOGGLE_COUNTER_MOD_EN
    localparam logic [WIDTH-1:0] TOP = 4'd9;
`else
    localparam logic [WIDTH-1:0] TOP = 4'd15;
`endif

    logic             clk;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             rst;
        logic             en;
        logic             up;
        logic             ld;
        logic [WIDTH-1:0] lv;
        logic             exp_tc;
        logic [WIDTH-1:0] exp_q;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[$];
    logic [WIDTH:0] exp_q[$];

    logic [WIDTH-1:0] m_q;
    logic             m_ovf;

    t_toggle_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic u, logic l, logic [WIDTH-1:0] v,
                                logic t, logic [WIDTH-1:0] nq, logic no);
        vec_t x;
        x.rst = r; x.en = e; x.up = u; x.ld = l; x.lv = v;
        x.exp_tc = t; x.exp_q = nq; x.exp_ovf = no;
        return x;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    // Drive one cycle: check tc before the edge, then q/ovf after it via the queue.
    task automatic apply(input vec_t v, input int step);
        logic [WIDTH:0] e;
        @(negedge clk);
        reset = v.rst; en = v.en; up = v.up; load = v.ld; load_val = v.lv;
        #1;
        check("tc", step, {31'd0, tc}, {31'd0, v.exp_tc});
        exp_q.push_back({v.exp_ovf, v.exp_q});
        m_q   = v.exp_q;
        m_ovf = v.exp_ovf;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", step, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("q", step, {28'd0, q}, {28'd0, e[WIDTH-1:0]});
            check("ovf", step, {31'd0, ovf}, {31'd0, e[WIDTH]});
        end
    endtask

    // Arithmetic reference for the random phase, independent of the toggle structure.
    task automatic model_step(input logic r, input logic e, input logic u, input logic l,
                              input logic [WIDTH-1:0] v, output vec_t x);
        logic [WIDTH-1:0] nq;
        logic             no;
        logic             t;
        t  = e & ~l & (m_q == (u ? TOP : 4'd0));
        nq = m_q;
        no = m_ovf;
        if (r) begin
            nq = '0; no = 1'b0;
        end else if (l) begin
            nq = (v > TOP) ? TOP : v; no = 1'b0;
        end else if (e) begin
            if (u) begin
                if (m_q == TOP) begin nq = '0; no = 1'b1; end
                else nq = m_q + 1'b1;
            end else begin
                if (m_q == 0) begin nq = TOP; no = 1'b1; end
                else nq = m_q - 1'b1;
            end
        end
        x = mk(r, e, u, l, v, t, nq, no);
    endtask

    initial begin
        vec_t x;
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        m_q = '0; m_ovf = 1'b0;

        // Reset dominates load and en; tc low because load is high.
        vecs.push_back(mk(1, 1, 1, 1, 4'd5, 0, 4'd0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 4'd5, 0, 4'd0, 0));
`ifndef T_TOGGLE_COUNTER_MOD_EN
        // Up count 17 cycles from 0: 1..15, 0, 1; tc only at 15.
        for (int k = 0; k < 17; k++) begin
            vecs.push_back(mk(0, 1, 1, 0, 4'd0, (k == 15),
                              4'((k + 1) % 16), (k >= 15)));
        end
        // Load 3 with en high: no count. Then down 3,2,1,0 -> 15 -> 14.
        vecs.push_back(mk(0, 1, 0, 1, 4'd3, 0, 4'd3, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 1, 4'd15, 1));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd14, 1));
        // Priority: q=7, load 9 with en=1; then hold 3 cycles.
        vecs.push_back(mk(0, 0, 1, 1, 4'd7, 0, 4'd7, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'd9, 0, 4'd9, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd9, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0, 0, 4'd9, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 0, 4'd9, 0));
        // Reset mid-count at 12, then resume.
        vecs.push_back(mk(0, 0, 1, 1, 4'd11, 0, 4'd11, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'd0, 0, 4'd12, 0));
        vecs.push_back(mk(1, 1, 1, 0, 4'd0, 0, 4'd0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'd0, 0, 4'd1, 0));
        // Direction change takes effect on the same edge.
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 1, 4'd15, 1));
        vecs.push_back(mk(0, 1, 1, 0, 4'd0, 1, 4'd0, 1));
`else
        // Modulo-10: 8, 9, 0 with tc at 9; down from 0 gives 9; load 13 clamps to 9.
        vecs.push_back(mk(0, 0, 1, 1, 4'd8, 0, 4'd8, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'd0, 0, 4'd9, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'd0, 1, 4'd0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 1, 4'd9, 1));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd8, 1));
        vecs.push_back(mk(0, 1, 0, 1, 4'd13, 0, 4'd9, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'd15, 0, 4'd9, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'd0, 1, 4'd0, 1));
`endif

        foreach (vecs[i]) begin
            apply(vecs[i], i);
        end

        // Random walk against the arithmetic model.
        for (int s = 0; s < 60; s++) begin
            model_step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                       4'($urandom_range(0, 15)), x);
            apply(x, 1000 + s);
        end

        if (exp_q.size() != 0) begin
            check("queue_drain", 0, exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
